// File: rtl/eia232_tx_arbiter_if.sv
// eia232_tx_arbiter_if: requester words in, grant pulses out, transmitter send/wrdata/busy handshake
interface eia232_tx_arbiter_if;
  logic [2:0] req;
  logic [95:0] req_data;
  logic [2:0] ack;
  logic tx_busy;
  logic tx_send;
  logic [31:0] tx_wrdata;
  modport master (input req, req_data, tx_busy, output ack, tx_send, tx_wrdata);
  modport slave (output req, req_data, tx_busy, input ack, tx_send, tx_wrdata);
endinterface

// File: rtl/eia232_tx_arbiter.sv
// eia232_tx_arbiter: shares one EIA232 transmitter among three word requesters with XON/XOFF and busy timeout
module eia232_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 16,
  parameter int COUNT_W = 16
) (
  input  logic clock,
  input  logic reset,
  eia232_tx_arbiter_if.master bus,
  input  logic xon,
  input  logic xoff,
  output logic paused,
  output logic [1:0] grant_id,
  output logic [COUNT_W-1:0] sent_count,
  output logic timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [1:0] rr_ptr, win, pick;
  logic [7:0] timer;
  logic [31:0] word, pick_data;
  // requester 0 always wins; 1 and 2 alternate starting from rr_ptr
  always_comb begin
    pick = bus.req[0] ? 2'd0 : bus.req[rr_ptr] ? rr_ptr : 2'd3 - rr_ptr;
    pick_data = pick == 2'd0 ? bus.req_data[31:0] : pick == 2'd1 ? bus.req_data[63:32] : bus.req_data[95:64];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= 2'd1;
      win <= 2'd0;
      timer <= 8'd0;
      word <= 32'd0;
      bus.ack <= 3'b000;
      bus.tx_send <= 1'b0;
      bus.tx_wrdata <= 32'd0;
      paused <= 1'b0;
      grant_id <= 2'd3;
      sent_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      bus.ack <= 3'b000;
      bus.tx_send <= 1'b0;
      timeout_err <= 1'b0;
      paused <= xoff ? 1'b1 : xon ? 1'b0 : paused;
      case (state)
        IDLE: if (|bus.req && !paused && !bus.tx_busy) begin
          win <= pick;
          word <= pick_data;
          rr_ptr <= pick == 2'd0 ? rr_ptr : 2'd3 - pick;
          state <= ISSUE;
        end
        ISSUE: begin
          bus.tx_send <= 1'b1;
          bus.tx_wrdata <= word;
          bus.ack <= 3'b001 << win;
          grant_id <= win;
          sent_count <= sent_count + 1'b1;
          timer <= 8'd0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (bus.tx_busy) state <= WAIT_DONE;
          else if (timer == 8'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state <= IDLE;
          end else timer <= timer + 8'd1;
        default: if (!bus.tx_busy) state <= IDLE;
      endcase
    end
  end
endmodule
